// File: rtl/miner_pkg.sv
// Shared constants for the multi-core miner CSR block: register map,
// CTRL/STATUS/IRQ bit positions, ID word and FSM state encoding.
package miner_pkg;

  localparam logic [31:0] MINER_ID = 32'h5348_4133;  // "SHA3"

  localparam logic [4:0] REG_ID        = 5'd0;
  localparam logic [4:0] REG_STATUS    = 5'd1;
  localparam logic [4:0] REG_CTRL      = 5'd2;
  localparam logic [4:0] REG_IRQ_STAT  = 5'd3;
  localparam logic [4:0] REG_IRQ_MASK  = 5'd4;
  localparam logic [4:0] REG_SOLN_LO   = 5'd5;
  localparam logic [4:0] REG_SOLN_HI   = 5'd6;
  localparam logic [4:0] REG_SOLN_CORE = 5'd7;
  localparam logic [4:0] REG_SOLN_POP  = 5'd8;
  localparam logic [4:0] REG_START_LO  = 5'd10;
  localparam logic [4:0] REG_START_HI  = 5'd11;
  localparam logic [4:0] REG_STRIDE_LO = 5'd12;
  localparam logic [4:0] REG_STRIDE_HI = 5'd13;
  localparam logic [4:0] REG_HEADER0   = 5'd16;
  localparam logic [4:0] REG_DIFF0     = 5'd24;

  localparam int unsigned CTRL_RUN  = 0;
  localparam int unsigned CTRL_HALT = 1;
  localparam int unsigned CTRL_TEST = 2;

  localparam int unsigned IRQ_FOUND = 0;
  localparam int unsigned IRQ_OVF   = 1;

  localparam int unsigned STAT_RUNNING   = 0;
  localparam int unsigned STAT_NEMPTY    = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_CNT_LSB   = 3;
  localparam int unsigned STAT_CORES_LSB = 10;
  localparam int unsigned STAT_MAJ_LSB   = 16;
  localparam int unsigned STAT_MIN_LSB   = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_HALT
  } miner_state_t;

endpackage

// File: rtl/miner_soln_fifo.sv
// Synchronous solution FIFO of {core index, nonce}; a push on a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module miner_soln_fifo #(
  parameter int DW    = 68,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  always_comb begin
    o_empty = (r_cnt == '0);
    o_full  = r_cnt[AW];
    o_count = r_cnt;
    o_data  = r_mem[r_rp];
    w_rd    = i_pop && !o_empty;
    w_wr    = i_push && (!o_full || w_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/miner_csr_multi.sv
// Avalon-MM CSR block driving NUM_CORES miner cores: staggered launch over
// nonce sub-ranges, round-robin solution collection into a FIFO, level IRQ.
module miner_csr_multi
  import miner_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int NONCE_W    = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int MAJ_VER    = 1,
  parameter int MIN_VER    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   address,
  input  logic                         read,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic                         irq,
  output logic [255:0]                 core_header,
  output logic [255:0]                 core_difficulty,
  output logic                         core_test,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NONCE_W-1:0]           core_start_nonce,
  output logic                         core_halt,
  input  logic [NUM_CORES-1:0]         core_busy,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce
);

  localparam int HI_W  = NONCE_W - 32;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 4 + NONCE_W;

  logic [31:0]         r_hdr [8];
  logic [31:0]         r_dif [8];
  logic [31:0]         r_start_lo;
  logic [HI_W-1:0]     r_start_hi;
  logic [31:0]         r_stride_lo;
  logic [HI_W-1:0]     r_stride_hi;
  logic                r_test;
  logic [1:0]          r_mask;
  logic [1:0]          r_irq_stat;
  logic                r_ovf;
  logic                r_irq;
  miner_state_t        r_state;
  miner_state_t        w_state_nxt;
  logic [3:0]          r_idx;
  logic [NONCE_W-1:0]  r_acc;
  logic                r_run_seen;
  logic [NUM_CORES-1:0] r_pend;
  logic [NONCE_W-1:0]  r_pnonce [NUM_CORES];
  logic [3:0]          r_last;

  logic                w_run;
  logic                w_halt;
  logic                w_pop;
  logic [1:0]          w_w1c;
  logic [1:0]          w_mask_nxt;
  logic [1:0]          w_stat_nxt;
  logic                w_gnt_vld;
  logic [3:0]          w_gnt_idx;
  logic [NONCE_W-1:0]  w_gnt_nonce;
  logic [NUM_CORES-1:0] w_grant;
  logic                w_drop;
  logic                w_ovf_evt;
  logic [ENT_W-1:0]    w_head;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [31:0]         w_status;
  logic [31:0]         w_rdata;

  always_comb begin
    w_run      = write && (address == REG_CTRL) && writedata[CTRL_RUN];
    w_halt     = write && (address == REG_CTRL) && writedata[CTRL_HALT];
    w_pop      = write && (address == REG_SOLN_POP);
    w_w1c      = (write && (address == REG_IRQ_STAT)) ? writedata[1:0] : 2'b00;
    w_mask_nxt = (write && (address == REG_IRQ_MASK)) ? writedata[1:0] : r_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 8; k++) begin
        r_hdr[k] <= '0;
        r_dif[k] <= '0;
      end
      r_start_lo  <= '0;
      r_start_hi  <= '0;
      r_stride_lo <= '0;
      r_stride_hi <= '0;
      r_test      <= 1'b0;
      r_mask      <= '0;
    end else if (write) begin
      case (address)
        REG_CTRL:      r_test      <= writedata[CTRL_TEST];
        REG_IRQ_MASK:  r_mask      <= writedata[1:0];
        REG_START_LO:  r_start_lo  <= writedata;
        REG_START_HI:  r_start_hi  <= writedata[HI_W-1:0];
        REG_STRIDE_LO: r_stride_lo <= writedata;
        REG_STRIDE_HI: r_stride_hi <= writedata[HI_W-1:0];
        default: begin
          if (address[4:3] == REG_HEADER0[4:3]) r_hdr[address[2:0]] <= writedata;
          if (address[4:3] == REG_DIFF0[4:3])   r_dif[address[2:0]] <= writedata;
        end
      endcase
    end
  end

  // Word 0 of each 8-word block is the most significant 32 bits.
  always_comb begin
    core_header     = '0;
    core_difficulty = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      core_header[(7-k)*32 +: 32]     = r_hdr[k];
      core_difficulty[(7-k)*32 +: 32] = r_dif[k];
    end
    core_test = r_test;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_run) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        if (w_halt)                          w_state_nxt = ST_HALT;
        else if (r_idx == 4'(NUM_CORES - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt)                               w_state_nxt = ST_HALT;
        else if (r_run_seen && (core_busy == '0)) w_state_nxt = ST_IDLE;
      end
      ST_HALT:   if (core_busy == '0) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    core_start = '0;
    for (int unsigned c = 0; c < NUM_CORES; c++)
      core_start[c] = (r_state == ST_LAUNCH) && (r_idx == 4'(c));
    core_start_nonce = r_acc;
    core_halt        = (r_state == ST_HALT);
  end

  // Accumulator tracks START + idx*STRIDE; reloaded every idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_acc      <= '0;
      r_run_seen <= 1'b0;
    end else begin
      r_run_seen <= (r_state == ST_RUN);
      if (r_state == ST_IDLE) begin
        r_idx <= '0;
        r_acc <= {r_start_hi, r_start_lo};
      end else if (r_state == ST_LAUNCH) begin
        r_idx <= r_idx + 1'b1;
        r_acc <= r_acc + {r_stride_hi, r_stride_lo};
      end
    end
  end

  // Round-robin: search starts at the core after the previous winner.
  always_comb begin
    w_gnt_vld   = 1'b0;
    w_gnt_idx   = '0;
    w_gnt_nonce = '0;
    w_grant     = '0;
    for (int unsigned off = 1; off <= NUM_CORES; off++)
      for (int unsigned c = 0; c < NUM_CORES; c++)
        if (!w_gnt_vld && r_pend[c] &&
            (((32'(r_last) + off) % 32'(NUM_CORES)) == c)) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = 4'(c);
        end
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      w_grant[c] = w_gnt_vld && (w_gnt_idx == 4'(c));
      if (w_grant[c]) w_gnt_nonce = r_pnonce[c];
    end
    w_drop     = w_gnt_vld && w_full && !(w_pop && !w_empty);
    w_ovf_evt  = w_drop || |(core_found & r_pend & ~w_grant);
    w_stat_nxt = (r_irq_stat & ~w_w1c) | {w_ovf_evt, w_gnt_vld};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_last <= 4'(NUM_CORES - 1);
      for (int unsigned c = 0; c < NUM_CORES; c++) r_pnonce[c] <= '0;
    end else begin
      if (w_gnt_vld) r_last <= w_gnt_idx;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
        if (core_found[c]) begin
          r_pend[c] <= 1'b1;
          if (!r_pend[c] || w_grant[c])
            r_pnonce[c] <= core_nonce[c*NONCE_W +: NONCE_W];
        end else if (w_grant[c]) begin
          r_pend[c] <= 1'b0;
        end
      end
    end
  end

  miner_soln_fifo #(
    .DW    (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_gnt_vld),
    .i_data  ({w_gnt_idx, w_gnt_nonce}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_stat <= '0;
      r_ovf      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_stat <= w_stat_nxt;
      r_ovf      <= (r_ovf && !w_w1c[IRQ_OVF]) || w_ovf_evt;
      r_irq      <= |(w_stat_nxt & w_mask_nxt);
    end
  end

  assign irq = r_irq;

  always_comb begin
    w_status                            = '0;
    w_status[STAT_RUNNING]              = (r_state != ST_IDLE);
    w_status[STAT_NEMPTY]               = !w_empty;
    w_status[STAT_OVF]                  = r_ovf;
    w_status[STAT_CNT_LSB +: 7]         = 7'(w_count);
    w_status[STAT_CORES_LSB +: 5]       = 5'(NUM_CORES);
    w_status[STAT_MAJ_LSB +: 4]         = 4'(MAJ_VER);
    w_status[STAT_MIN_LSB +: 4]         = 4'(MIN_VER);
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      REG_ID:        w_rdata = MINER_ID;
      REG_STATUS:    w_rdata = w_status;
      REG_CTRL:      w_rdata[CTRL_TEST] = r_test;
      REG_IRQ_STAT:  w_rdata[1:0] = r_irq_stat;
      REG_IRQ_MASK:  w_rdata[1:0] = r_mask;
      REG_SOLN_LO:   if (!w_empty) w_rdata = w_head[31:0];
      REG_SOLN_HI:   if (!w_empty) w_rdata = 32'(w_head[NONCE_W-1:32]);
      REG_SOLN_CORE: if (!w_empty) w_rdata[3:0] = w_head[ENT_W-1 -: 4];
      REG_START_LO:  w_rdata = r_start_lo;
      REG_START_HI:  w_rdata = 32'(r_start_hi);
      REG_STRIDE_LO: w_rdata = r_stride_lo;
      REG_STRIDE_HI: w_rdata = 32'(r_stride_hi);
      default: begin
        if (address[4:3] == REG_HEADER0[4:3]) w_rdata = r_hdr[address[2:0]];
        if (address[4:3] == REG_DIFF0[4:3])   w_rdata = r_dif[address[2:0]];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       readdata <= '0;
    else if (read) readdata <= w_rdata;
  end

endmodule

// File: tb/tb_miner_csr_multi.sv
// Scoreboard bench for miner_csr_multi: CSR access, staggered launch, halt,
// round-robin solution FIFO with overflow, IRQ and mid-run reset.
module tb_miner_csr_multi;

  localparam int NC = 4;
  localparam int NW = 64;
  localparam int FD = 4;

  localparam logic [4:0] A_ID = 5'd0, A_STATUS = 5'd1, A_CTRL = 5'd2, A_ISTAT = 5'd3,
                         A_IMASK = 5'd4, A_SLO = 5'd5, A_SHI = 5'd6, A_SCORE = 5'd7,
                         A_POP = 5'd8, A_STLO = 5'd10, A_STHI = 5'd11, A_SDLO = 5'd12,
                         A_SDHI = 5'd13;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [255:0]      core_header;
  logic [255:0]      core_difficulty;
  logic              core_test;
  logic [NC-1:0]     core_start;
  logic [NW-1:0]     core_start_nonce;
  logic              core_halt;
  logic [NC-1:0]     core_busy;
  logic [NC-1:0]     core_found;
  logic [NC*NW-1:0]  core_nonce;

  always #5 clk = ~clk;

  miner_csr_multi #(
    .NUM_CORES  (NC),
    .NONCE_W    (NW),
    .FIFO_DEPTH (FD),
    .MAJ_VER    (1),
    .MIN_VER    (0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .address          (address),
    .read             (read),
    .write            (write),
    .writedata        (writedata),
    .readdata         (readdata),
    .irq              (irq),
    .core_header      (core_header),
    .core_difficulty  (core_difficulty),
    .core_test        (core_test),
    .core_start       (core_start),
    .core_start_nonce (core_start_nonce),
    .core_halt        (core_halt),
    .core_busy        (core_busy),
    .core_found       (core_found),
    .core_nonce       (core_nonce)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [67:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_nonce(input int c, input logic [63:0] n);
    core_nonce[c*NW +: NW] = n;
  endtask

  task automatic strobe(input logic [NC-1:0] m);
    core_found = m;
    @(negedge clk);
    core_found = '0;
  endtask

  function automatic logic [31:0] status_exp(input logic run, input logic nemp,
                                             input logic ovf, input int cnt);
    return 32'(run) | (32'(nemp) << 1) | (32'(ovf) << 2) | (32'(cnt) << 3) |
           (32'(NC) << 10) | (32'd1 << 16);
  endfunction

  task automatic pop_check(input string tag);
    logic [31:0] cr, lo, hi;
    logic [67:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 68'd0;
    bus_read(A_SCORE, cr);
    bus_read(A_SLO, lo);
    bus_read(A_SHI, hi);
    check({tag, "_core"}, 64'(cr), 64'(e[67:64]));
    check({tag, "_nonce"}, {hi, lo}, e[63:0]);
    bus_write(A_POP, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    core_busy = '0; core_found = '0; core_nonce = '0;
    idle(3);
    check("rst_readdata", 64'(readdata), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_start", 64'(core_start), 64'd0);
    check("rst_halt", 64'(core_halt), 64'd0);
    check("rst_test", 64'(core_test), 64'd0);
    rst = 1'b0;
    idle(1);

    // ID, hold, STATUS, unmapped
    bus_read(A_ID, d);
    check("id", 64'(d), 64'h5348_4133);
    idle(1);
    check("rd_hold", 64'(readdata), 64'h5348_4133);
    bus_read(A_STATUS, d);
    check("status_reset", 64'(d), 64'(status_exp(0, 0, 0, 0)));
    bus_write(5'd9, 32'hFFFF_FFFF);
    bus_read(5'd9, d);
    check("unmapped9", 64'(d), 64'd0);
    bus_read(5'd14, d);
    check("unmapped14", 64'(d), 64'd0);

    // CTRL.test, header/difficulty ordering
    bus_write(A_CTRL, 32'h4);
    check("test_out", 64'(core_test), 64'd1);
    bus_read(A_CTRL, d);
    check("ctrl_rd", 64'(d), 64'h4);
    bus_write(A_CTRL, 32'h0);
    bus_write(5'd16, 32'hDEAD_BEEF);
    bus_write(5'd23, 32'h1234_5678);
    bus_write(5'd24, 32'hCAFE_F00D);
    check("hdr_top", 64'(core_header[255:224]), 64'hDEAD_BEEF);
    check("hdr_bot", 64'(core_header[31:0]), 64'h1234_5678);
    check("diff_top", 64'(core_difficulty[255:224]), 64'hCAFE_F00D);
    bus_read(5'd23, d);
    check("hdr_rd", 64'(d), 64'h1234_5678);

    // halt in IDLE ignored
    bus_write(A_CTRL, 32'h2);
    check("idle_halt", 64'(core_halt), 64'd0);

    // staggered launch
    bus_write(A_STLO, 32'h100);
    bus_write(A_STHI, 32'h0);
    bus_write(A_SDLO, 32'h1000);
    bus_write(A_SDHI, 32'h0);
    bus_read(A_SDLO, d);
    check("stride_rd", 64'(d), 64'h1000);
    core_busy = '1;
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < NC; i++) begin
      check($sformatf("launch_start%0d", i), 64'(core_start), 64'(1 << i));
      check($sformatf("launch_nonce%0d", i), core_start_nonce, 64'h100 + 64'(i) * 64'h1000);
      idle(1);
    end
    check("launch_done", 64'(core_start), 64'd0);
    bus_write(A_CTRL, 32'h1);
    check("run_in_run", 64'(core_start), 64'd0);
    idle(2);
    check("run_in_run2", 64'(core_start), 64'd0);
    bus_read(A_STATUS, d);
    check("running", 64'(d[0]), 64'd1);
    core_busy = '0;
    idle(2);
    bus_read(A_STATUS, d);
    check("run_done", 64'(d), 64'(status_exp(0, 0, 0, 0)));

    // simultaneous finds, round-robin order, IRQ
    bus_write(A_IMASK, 32'h1);
    set_nonce(1, 64'hA);
    set_nonce(3, 64'hB);
    sb.push_back({4'd1, 64'hA});
    sb.push_back({4'd3, 64'hB});
    strobe(4'b1010);
    idle(3);
    check("irq_found", 64'(irq), 64'd1);
    bus_read(A_STATUS, d);
    check("status_2", 64'(d), 64'(status_exp(0, 1, 0, 2)));
    pop_check("rr0");
    pop_check("rr1");
    bus_read(A_STATUS, d);
    check("status_empty", 64'(d), 64'(status_exp(0, 0, 0, 0)));
    check("irq_sticky", 64'(irq), 64'd1);
    bus_write(A_ISTAT, 32'h1);
    check("irq_cleared", 64'(irq), 64'd0);
    bus_read(A_ISTAT, d);
    check("istat_cleared", 64'(d), 64'd0);

    // fill FIFO, overflow
    for (int c = 0; c < NC; c++) begin
      set_nonce(c, 64'h100 + 64'(c));
      sb.push_back({4'(c), 64'h100 + 64'(c)});
      strobe(4'(1 << c));
      idle(2);
    end
    set_nonce(0, 64'h999);
    strobe(4'b0001);
    idle(3);
    bus_read(A_STATUS, d);
    check("status_full", 64'(d), 64'(status_exp(0, 1, 1, FD)));
    bus_read(A_ISTAT, d);
    check("istat_ovf", 64'(d), 64'h3);
    bus_write(A_ISTAT, 32'h2);
    bus_read(A_STATUS, d);
    check("ovf_w1c", 64'(d), 64'(status_exp(0, 1, 0, FD)));

    // push and pop in the same cycle on a full FIFO
    bus_read(A_SLO, d);
    check("head_before", 64'(d), sb[0][63:0]);
    set_nonce(1, 64'h777);
    core_found = 4'b0010;
    idle(1);
    core_found = '0;
    bus_write(A_POP, 32'h0);
    void'(sb.pop_front());
    sb.push_back({4'd1, 64'h777});
    idle(2);
    bus_read(A_STATUS, d);
    check("full_pushpop", 64'(d), 64'(status_exp(0, 1, 0, FD)));
    for (int i = 0; i < FD; i++) pop_check($sformatf("drain%0d", i));
    pop_check("empty_pop");
    bus_read(A_STATUS, d);
    check("status_drained", 64'(d), 64'(status_exp(0, 0, 0, 0)));
    bus_write(A_ISTAT, 32'h3);

    // halt during launch; run during HALT ignored
    core_busy = '1;
    bus_write(A_CTRL, 32'h1);
    check("h_start0", 64'(core_start), 64'b0001);
    idle(1);
    check("h_start1", 64'(core_start), 64'b0010);
    bus_write(A_CTRL, 32'h2);
    check("h_abort", 64'(core_start), 64'd0);
    check("h_halt", 64'(core_halt), 64'd1);
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("h_nostart%0d", i), 64'(core_start), 64'd0);
      check($sformatf("h_hold%0d", i), 64'(core_halt), 64'd1);
      idle(1);
    end
    bus_read(A_STATUS, d);
    check("h_running", 64'(d[0]), 64'd1);
    core_busy = '0;
    idle(1);
    check("h_released", 64'(core_halt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("h_idle_start%0d", i), 64'(core_start), 64'd0);
      idle(1);
    end
    bus_read(A_STATUS, d);
    check("h_idle", 64'(d), 64'(status_exp(0, 0, 0, 0)));

    // reset during RUN with a non-empty FIFO
    core_busy = '1;
    bus_write(A_IMASK, 32'h3);
    bus_write(A_CTRL, 32'h1);
    idle(5);
    set_nonce(2, 64'h55);
    strobe(4'b0100);
    idle(3);
    check("pre_rst_irq", 64'(irq), 64'd1);
    bus_read(A_STATUS, d);
    check("pre_rst_status", 64'(d), 64'(status_exp(1, 1, 0, 1)));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    sb.delete();
    check("mid_rst_irq", 64'(irq), 64'd0);
    check("mid_rst_halt", 64'(core_halt), 64'd0);
    check("mid_rst_start", 64'(core_start), 64'd0);
    check("mid_rst_rdata", 64'(readdata), 64'd0);
    bus_read(A_STATUS, d);
    check("post_rst_status", 64'(d), 64'(status_exp(0, 0, 0, 0)));
    bus_read(A_IMASK, d);
    check("post_rst_mask", 64'(d), 64'd0);
    pop_check("post_rst_soln");
    core_busy = '0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
